// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: widths, register indices, control layout
// and the ID/EX pipeline bundle.
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int CTRL_W    = 16;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    // Field offsets inside the opaque control bundle, shared by ID and EX
    localparam int CTRL_ALU_OP_LSB = 0;
    localparam int CTRL_ALU_OP_W   = 4;
    localparam int CTRL_SRC_B_IMM  = 4;
    localparam int CTRL_MEM_RD     = 5;
    localparam int CTRL_MEM_WR     = 6;
    localparam int CTRL_REG_WR     = 7;
    localparam int CTRL_BRANCH     = 8;
    localparam int CTRL_JUMP       = 9;
    localparam int CTRL_FUNCT3_LSB = 10;
    localparam int CTRL_FUNCT3_W   = 3;

    typedef logic [XLEN-1:0]      xlen_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [CTRL_W-1:0]    ctrl_t;

    typedef struct packed {
        xlen_t    pc;
        xlen_t    imm;
        reg_idx_t rs1;
        reg_idx_t rs2;
        reg_idx_t rd;
        ctrl_t    ctrl;
        xlen_t    op1;
        xlen_t    op2;
    } id_ex_t;

    function automatic logic wb_hit(
        input logic     we,
        input reg_idx_t rd,
        input reg_idx_t idx
    );
        return we && (rd != REG_ZERO) && (rd == idx);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary: decode handshake, writeback snoop, EX handshake.
// The stage itself uses the slave view.
interface id_ex_stage_if;
    import riscv_pkg::*;

    logic     flush;
    logic     id_valid;
    logic     id_ready;
    xlen_t    id_pc;
    reg_idx_t id_rs1;
    reg_idx_t id_rs2;
    reg_idx_t id_rd;
    xlen_t    id_imm;
    ctrl_t    id_ctrl;
    xlen_t    id_rd1;
    xlen_t    id_rd2;

    logic     wb_we;
    reg_idx_t wb_rd;
    xlen_t    wb_data;

    logic     ex_valid;
    logic     ex_ready;
    xlen_t    ex_pc;
    xlen_t    ex_imm;
    reg_idx_t ex_rs1;
    reg_idx_t ex_rs2;
    reg_idx_t ex_rd;
    ctrl_t    ex_ctrl;
    xlen_t    ex_op1;
    xlen_t    ex_op2;

    modport slave (
        input  flush, id_valid, id_pc,
        input  id_rs1, id_rs2, id_rd,
        input  id_imm, id_ctrl,
        input  id_rd1, id_rd2,
        input  wb_we, wb_rd, wb_data,
        input  ex_ready,
        output id_ready, ex_valid,
        output ex_pc, ex_imm,
        output ex_rs1, ex_rs2, ex_rd,
        output ex_ctrl, ex_op1, ex_op2
    );

    modport master (
        output flush, id_valid, id_pc,
        output id_rs1, id_rs2, id_rd,
        output id_imm, id_ctrl,
        output id_rd1, id_rd2,
        output wb_we, wb_rd, wb_data,
        output ex_ready,
        input  id_ready, ex_valid,
        input  ex_pc, ex_imm,
        input  ex_rs1, ex_rs2, ex_rd,
        input  ex_ctrl, ex_op1, ex_op2
    );

endinterface

// File: rtl/operand_bypass.sv
// One operand mux: x0 forces zero, a live writeback to the same
// register wins, otherwise the supplied register value passes.
module operand_bypass
    import riscv_pkg::*;
(
    input  reg_idx_t idx_i,
    input  xlen_t    rf_i,
    input  logic     wb_we_i,
    input  reg_idx_t wb_rd_i,
    input  xlen_t    wb_data_i,
    output xlen_t    val_o
);

    always_comb begin
        val_o = rf_i;
        unique case (1'b1)
            idx_i == REG_ZERO:
                val_o = '0;
            wb_hit(wb_we_i, wb_rd_i, idx_i):
                val_o = wb_data_i;
            default:
                val_o = rf_i;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush and
// writeback bypass on both capture and stalled entries.
module id_ex_stage
    import riscv_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);

    logic   valid_q, valid_d;
    id_ex_t ent_q, ent_d;
    logic   load, held;
    xlen_t  cap_op1, cap_op2;
    xlen_t  hold_op1, hold_op2;

    operand_bypass u_cap1 (
        .idx_i     (bus.id_rs1),
        .rf_i      (bus.id_rd1),
        .wb_we_i   (bus.wb_we),
        .wb_rd_i   (bus.wb_rd),
        .wb_data_i (bus.wb_data),
        .val_o     (cap_op1)
    );

    operand_bypass u_cap2 (
        .idx_i     (bus.id_rs2),
        .rf_i      (bus.id_rd2),
        .wb_we_i   (bus.wb_we),
        .wb_rd_i   (bus.wb_rd),
        .wb_data_i (bus.wb_data),
        .val_o     (cap_op2)
    );

    operand_bypass u_hold1 (
        .idx_i     (ent_q.rs1),
        .rf_i      (ent_q.op1),
        .wb_we_i   (bus.wb_we),
        .wb_rd_i   (bus.wb_rd),
        .wb_data_i (bus.wb_data),
        .val_o     (hold_op1)
    );

    operand_bypass u_hold2 (
        .idx_i     (ent_q.rs2),
        .rf_i      (ent_q.op2),
        .wb_we_i   (bus.wb_we),
        .wb_rd_i   (bus.wb_rd),
        .wb_data_i (bus.wb_data),
        .val_o     (hold_op2)
    );

    assign bus.id_ready = ~valid_q | bus.ex_ready;

    // load implies id_ready, held implies ~id_ready: never both
    assign load = bus.id_valid & bus.id_ready & ~bus.flush;
    assign held = valid_q & ~bus.ex_ready & ~bus.flush;

    always_comb begin
        valid_d = valid_q;
        ent_d   = ent_q;
        unique case (1'b1)
            bus.flush: begin
                valid_d = 1'b0;
            end
            load: begin
                valid_d    = 1'b1;
                ent_d.pc   = bus.id_pc;
                ent_d.imm  = bus.id_imm;
                ent_d.rs1  = bus.id_rs1;
                ent_d.rs2  = bus.id_rs2;
                ent_d.rd   = bus.id_rd;
                ent_d.ctrl = bus.id_ctrl;
                ent_d.op1  = cap_op1;
                ent_d.op2  = cap_op2;
            end
            held: begin
                ent_d.op1 = hold_op1;
                ent_d.op2 = hold_op2;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ent_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ent_q   <= ent_d;
        end
    end

    assign bus.ex_valid = valid_q;
    assign bus.ex_pc    = ent_q.pc;
    assign bus.ex_imm   = ent_q.imm;
    assign bus.ex_rs1   = ent_q.rs1;
    assign bus.ex_rs2   = ent_q.rs2;
    assign bus.ex_rd    = ent_q.rd;
    assign bus.ex_ctrl  = ent_q.ctrl;
    assign bus.ex_op1   = ent_q.op1;
    assign bus.ex_op2   = ent_q.op2;

endmodule
